// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch redirect, flush and stall control with optional perf counters
// Optional feature: define FETCH_PERF_CNT_EN to build the mispredict and stall-cycle counters.
module fetch_redirect_ctrl #(
    parameter int CNT_W       = 16,
    parameter int RECOVER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_e,
    input  logic             PCSrcE,
    input  logic             pred_taken_e,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      PCPlus4E,
    input  logic             load_use_stall_i,
    input  logic             imem_ready_i,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] mispredict_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] RCNT_INIT = 3'(RECOVER_CYC);

    state_t      state;
    state_t      state_nx;
    logic        pend;
    logic        pend_nx;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nx;
    logic [2:0]  rcnt;
    logic [2:0]  rcnt_nx;
    logic [31:0] last_pc;
    logic [31:0] redir_pc;
    logic [31:0] fix_pc;
    logic        mp;

    assign fix_pc = PCSrcE ? PCTargetE : PCPlus4E;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pend    <= 1'b0;
            pend_pc <= 32'd0;
            rcnt    <= 3'd0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            pend_pc <= pend_pc_nx;
            rcnt    <= rcnt_nx;
        end
    end

    // Outputs are gated by rst so the pipeline sees no stall/flush/redirect during reset.
    always_comb begin
        state_nx   = state;
        pend_nx    = pend;
        pend_pc_nx = pend_pc;
        rcnt_nx    = rcnt;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        redirect_o = 1'b0;
        redir_pc   = fix_pc;
        mp         = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    mp = branch_e & (PCSrcE ^ pred_taken_e);
                    if (mp && imem_ready_i) begin
                        redirect_o = 1'b1;
                        FlushD     = 1'b1;
                        FlushE     = 1'b1;
                        rcnt_nx    = RCNT_INIT;
                        state_nx   = RECOVER;
                    end else if (mp) begin
                        // Memory busy: park the corrected PC until the fetch can be redirected.
                        pend_nx    = 1'b1;
                        pend_pc_nx = fix_pc;
                        FlushE     = 1'b1;
                        StallF     = 1'b1;
                        StallD     = 1'b1;
                        state_nx   = MEMWAIT;
                    end else if (load_use_stall_i) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (!imem_ready_i) begin
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        FlushD   = 1'b1;
                        state_nx = MEMWAIT;
                    end
                end
                RECOVER: begin
                    FlushD = 1'b1;
                    StallF = !imem_ready_i;
                    if (rcnt <= 3'd1) begin
                        rcnt_nx  = 3'd0;
                        state_nx = RUN;
                    end else begin
                        rcnt_nx = rcnt - 3'd1;
                    end
                end
                MEMWAIT: begin
                    if (!imem_ready_i) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushD = 1'b1;
                    end else if (pend) begin
                        redirect_o = 1'b1;
                        redir_pc   = pend_pc;
                        FlushD     = 1'b1;
                        pend_nx    = 1'b0;
                        rcnt_nx    = RCNT_INIT;
                        state_nx   = RECOVER;
                    end else begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc <= 32'd0;
        end else if (redirect_o) begin
            last_pc <= redir_pc;
        end
    end

    assign redirect_pc_o = redirect_o ? redir_pc : last_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] mp_cnt;
    logic [CNT_W-1:0] st_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (mp && (mp_cnt != {CNT_W{1'b1}})) begin
                mp_cnt <= mp_cnt + 1'b1;
            end
            if (StallF && (st_cnt != {CNT_W{1'b1}})) begin
                st_cnt <= st_cnt + 1'b1;
            end
        end
    end

    assign mispredict_cnt_o = mp_cnt;
    assign stall_cnt_o      = st_cnt;
`else
    assign mispredict_cnt_o = '0;
    assign stall_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

    localparam int CNT_W = 4;
    localparam int RCYC  = 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             branch_e = 1'b0;
    logic             PCSrcE = 1'b0;
    logic             pred_taken_e = 1'b0;
    logic [31:0]      PCTargetE = 32'd0;
    logic [31:0]      PCPlus4E = 32'd0;
    logic             load_use_stall_i = 1'b0;
    logic             imem_ready_i = 1'b1;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] mispredict_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_run  = 0;
    int n_fail = 0;

    fetch_redirect_ctrl #(.CNT_W(CNT_W), .RECOVER_CYC(RCYC)) dut (
        .clk(clk), .rst(rst), .branch_e(branch_e), .PCSrcE(PCSrcE),
        .pred_taken_e(pred_taken_e), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .load_use_stall_i(load_use_stall_i), .imem_ready_i(imem_ready_i),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .mispredict_cnt_o(mispredict_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline-control rules applied to the current inputs.
    int          m_recover_left = 0;
    bit          m_mem_wait = 0;
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = 0;
    logic [31:0] m_held_pc = 0;
    int          m_mp_cnt = 0;
    int          m_st_cnt = 0;

    always @(negedge clk) begin
        bit          e_sf, e_sd, e_fd, e_fe, e_rd, e_mp;
        logic [31:0] e_pc, cpc;
        int          e_mc, e_sc;
        e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0; e_rd = 0; e_mp = 0;
        cpc  = PCSrcE ? PCTargetE : PCPlus4E;
        e_pc = m_held_pc;
        if (rst) begin
            m_recover_left = 0; m_mem_wait = 0; m_pend = 0; m_pend_pc = 0;
            m_held_pc = 0; m_mp_cnt = 0; m_st_cnt = 0; e_pc = 0;
        end else if (m_recover_left > 0) begin
            e_fd = 1;
            e_sf = !imem_ready_i;
            m_recover_left--;
        end else if (m_mem_wait) begin
            if (!imem_ready_i) begin
                e_sf = 1; e_sd = 1; e_fd = 1;
            end else if (m_pend) begin
                e_rd = 1; e_pc = m_pend_pc; e_fd = 1;
                m_pend = 0; m_mem_wait = 0; m_recover_left = RCYC;
            end else begin
                m_mem_wait = 0;
            end
        end else begin
            e_mp = branch_e && (PCSrcE != pred_taken_e);
            if (e_mp && imem_ready_i) begin
                e_rd = 1; e_pc = cpc; e_fd = 1; e_fe = 1; m_recover_left = RCYC;
            end else if (e_mp) begin
                m_pend = 1; m_pend_pc = cpc; e_fe = 1; e_sf = 1; e_sd = 1; m_mem_wait = 1;
            end else if (load_use_stall_i) begin
                e_sf = 1; e_sd = 1; e_fe = 1;
            end else if (!imem_ready_i) begin
                e_sf = 1; e_sd = 1; e_fd = 1; m_mem_wait = 1;
            end
        end
`ifdef FETCH_PERF_CNT_EN
        e_mc = m_mp_cnt;
        e_sc = m_st_cnt;
`else
        e_mc = 0;
        e_sc = 0;
`endif
        chk("StallF", {31'd0, StallF}, {31'd0, e_sf});
        chk("StallD", {31'd0, StallD}, {31'd0, e_sd});
        chk("FlushD", {31'd0, FlushD}, {31'd0, e_fd});
        chk("FlushE", {31'd0, FlushE}, {31'd0, e_fe});
        chk("redirect_o", {31'd0, redirect_o}, {31'd0, e_rd});
        chk("redirect_pc_o", redirect_pc_o, e_pc);
        chk("mispredict_cnt_o", 32'(mispredict_cnt_o), e_mc);
        chk("stall_cnt_o", 32'(stall_cnt_o), e_sc);
        if (e_rd) m_held_pc = e_pc;
        if (!rst) begin
            if (e_mp && m_mp_cnt < CMAX) m_mp_cnt++;
            if (e_sf && m_st_cnt < CMAX) m_st_cnt++;
        end
    end

    task automatic cyc(input logic b, input logic s, input logic p, input logic [31:0] tgt,
                       input logic [31:0] p4, input logic lu, input logic rdy);
        @(posedge clk);
        #1;
        branch_e = b; PCSrcE = s; pred_taken_e = p; PCTargetE = tgt; PCPlus4E = p4;
        load_use_stall_i = lu; imem_ready_i = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        branch_e = 0; PCSrcE = 0; pred_taken_e = 0; load_use_stall_i = 0; imem_ready_i = 1;
        @(negedge clk);
        chk("rst_outputs", {28'd0, StallF, FlushD, FlushE, redirect_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_sat;
    int exp_two;

    initial begin
`ifdef FETCH_PERF_CNT_EN
        exp_sat = CMAX;
        exp_two = 2;
`else
        exp_sat = 0;
        exp_two = 0;
`endif
        @(negedge clk);
        chk("reset_ctrl", {27'd0, StallF, StallD, FlushD, FlushE, redirect_o}, 32'd0);
        chk("reset_pc", redirect_pc_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Taken branch predicted not-taken, memory ready.
        cyc(1, 1, 0, 32'h100, 32'h104, 0, 1);
        chk("mp_redirect", {31'd0, redirect_o}, 32'd1);
        chk("mp_pc", redirect_pc_o, 32'h100);
        chk("mp_flush", {30'd0, FlushD, FlushE}, 32'd3);
        idle(1);
        chk("recover_flushd", {31'd0, FlushD}, 32'd1);
        chk("recover_pc_held", redirect_pc_o, 32'h100);
        idle(1);
        chk("back_run", {28'd0, StallF, FlushD, FlushE, redirect_o}, 32'd0);

        // Not-taken mispredict beats a simultaneous load-use request.
        cyc(1, 0, 1, 32'h500, 32'h48, 1, 1);
        chk("prio_pc", redirect_pc_o, 32'h48);
        chk("prio_stallf", {31'd0, StallF}, 32'd0);
        idle(1);
        idle(1);
        chk("lu_discarded", {31'd0, StallF}, 32'd0);

        // Mispredict while memory busy for 3 cycles.
        cyc(1, 1, 0, 32'h200, 32'h204, 0, 0);
        chk("mw_stall0", {30'd0, StallF, redirect_o}, 32'd2);
        idle(0);
        chk("mw_stall1", {30'd0, StallF, redirect_o}, 32'd2);
        idle(0);
        chk("mw_stall2", {30'd0, StallF, redirect_o}, 32'd2);
        idle(1);
        chk("mw_redirect", {31'd0, redirect_o}, 32'd1);
        chk("mw_pc", redirect_pc_o, 32'h200);
        idle(1);

        // Two load-use cycles.
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("lu1", {29'd0, StallF, StallD, FlushE}, 32'd7);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("lu2", {29'd0, StallF, StallD, FlushE}, 32'd7);
        idle(1);
        chk("lu_end", {29'd0, StallF, StallD, FlushE}, 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt_o), exp_two);

        // Reset in MEMWAIT drops the pending redirect.
        cyc(1, 1, 0, 32'h300, 32'h304, 0, 0);
        idle(0);
        do_reset();
        idle(1);
        chk("rst_no_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_pc", redirect_pc_o, 32'd0);
        chk("rst_cnts", {mispredict_cnt_o, stall_cnt_o}, 32'd0);

        // Correct prediction, then plain memory wait with nothing pending.
        cyc(1, 1, 1, 32'h700, 32'h704, 0, 1);
        chk("correct_pred", {31'd0, redirect_o}, 32'd0);
        idle(0);
        chk("fetch_wait", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd14);
        idle(1);
        chk("fetch_resume", {29'd0, StallF, FlushD, redirect_o}, 32'd0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            cyc(1, i[0], !i[0], 32'h1000 + 32'(i), 32'h2000, 0, 1);
            idle(1);
        end
        chk("mp_cnt_sat", 32'(mispredict_cnt_o), exp_sat);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 1);
        end
        idle(1);
        chk("st_cnt_sat", 32'(stall_cnt_o), exp_sat);

        idle(1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
